// File: rtl/quiz_round_timer.sv
// quiz_round_timer: round sequencer and countdown timer for the speed quiz.
// slow_clk is sampled as data through a three-flop chain; each rising edge
// becomes a single-cycle tick that decrements the answer window in RUN.
// Optional build macro: QUIZ_TIMEOUT_PENALTY_EN. When it is defined, every
// timeout and every wrong answer takes one point off the score, saturating
// at zero.
module quiz_round_timer #(
    parameter int ROUND_TICKS = 20,
    parameter int NUM_ROUNDS  = 10
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       start,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic       new_question,
    output logic [7:0] time_left,
    output logic [3:0] round_idx,
    output logic [4:0] score,
    output logic       timeout,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASK  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LOAD_TICKS = 8'(ROUND_TICKS);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] time_left_nx;
    logic [3:0] round_nx;
    logic [4:0] score_nx;
    logic       timeout_nx;
    logic       round_end;

    logic       s1;
    logic       s2;
    logic       s3;
    logic       tick;

    // Synchronise slow_clk and keep one extra stage for rising-edge detection
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    // FSM state register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, round bookkeeping and scoring
    always_comb begin
        state_nx     = state;
        time_left_nx = time_left;
        round_nx     = round_idx;
        score_nx     = score;
        timeout_nx   = 1'b0;
        round_end    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = ASK;
                    score_nx = '0;
                    round_nx = '0;
                end
            end
            ASK: begin
                time_left_nx = LOAD_TICKS;
                state_nx     = RUN;
            end
            RUN: begin
                // An answer takes priority over a tick in the same cycle,
                // so a last-moment answer is scored rather than timed out.
                if (answer_valid) begin
                    round_end = 1'b1;
                    if (answer_correct) begin
                        score_nx = score + 5'd1;
                    end
`ifdef QUIZ_TIMEOUT_PENALTY_EN
                    else if (score != '0) begin
                        score_nx = score - 5'd1;
                    end
`endif
                end else if (tick) begin
                    if (time_left > 8'd1) begin
                        time_left_nx = time_left - 8'd1;
                    end else begin
                        time_left_nx = '0;
                        timeout_nx   = 1'b1;
                        round_end    = 1'b1;
`ifdef QUIZ_TIMEOUT_PENALTY_EN
                        if (score != '0) begin
                            score_nx = score - 5'd1;
                        end
`endif
                    end
                end

                if (round_end) begin
                    if (round_idx == LAST_ROUND) begin
                        state_nx = DONE;
                    end else begin
                        round_nx = round_idx + 4'd1;
                        state_nx = ASK;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            new_question <= 1'b0;
            time_left    <= '0;
            round_idx    <= '0;
            score        <= '0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            new_question <= (state_nx == ASK);
            time_left    <= time_left_nx;
            round_idx    <= round_nx;
            score        <= score_nx;
            timeout      <= timeout_nx;
            busy         <= (state_nx == ASK) || (state_nx == RUN);
            game_over    <= (state_nx == DONE);
        end
    end

endmodule
